// File: rtl/match_job_sequencer.sv
// Batch sequencer for the pattern-match engine: issues one engine start per job,
// waits for done with a per-job timeout, and keeps sticky batch status.
module match_job_sequencer #(
    parameter int NumJobsWidth  = 8,
    parameter int TimeoutCycles = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic [NumJobsWidth-1:0] num_jobs_i,
    output logic                    eng_start_o,
    output logic [NumJobsWidth-1:0] eng_job_idx_o,
    input  logic                    eng_done_i,
    input  logic                    eng_match_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    timeout_o,
    output logic                    aborted_o,
    output logic [NumJobsWidth-1:0] match_cnt_o,
    output logic                    first_match_vld_o,
    output logic [NumJobsWidth-1:0] first_match_idx_o
);

    localparam int TimerWidth = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
    localparam logic [TimerWidth-1:0]   TimerLast = TimerWidth'(TimeoutCycles - 1);
    localparam logic [NumJobsWidth-1:0] One       = NumJobsWidth'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                  state, state_d;
    logic                    start_q;
    logic                    armed;
    logic [NumJobsWidth-1:0] job_idx;
    logic [NumJobsWidth-1:0] job_count;
    logic [TimerWidth-1:0]   timer;

    logic rise;
    logic accept;
    logic empty_batch;
    logic job_done;
    logic advance;
    logic finish;
    logic timed_out;
    logic abort_take;

    // A rise only counts once start_i has been seen low since reset, so a level
    // held across reset release cannot launch a batch.
    assign rise = start_i & ~start_q & armed;

    always_comb begin
        state_d     = state;
        accept      = 1'b0;
        empty_batch = 1'b0;
        job_done    = 1'b0;
        advance     = 1'b0;
        finish      = 1'b0;
        timed_out   = 1'b0;
        abort_take  = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    accept = 1'b1;
                    if (num_jobs_i == '0) begin
                        empty_batch = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (abort_i) begin
                    abort_take = 1'b1;
                    state_d    = IDLE;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (abort_i) begin
                    abort_take = 1'b1;
                    state_d    = IDLE;
                end else if (eng_done_i) begin
                    job_done = 1'b1;
                    if (job_idx == job_count - One) begin
                        finish  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        advance = 1'b1;
                        state_d = ISSUE;
                    end
                end else if (timer == TimerLast) begin
                    timed_out = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            start_q           <= 1'b0;
            armed             <= 1'b0;
            job_idx           <= '0;
            job_count         <= '0;
            timer             <= '0;
            done_o            <= 1'b0;
            timeout_o         <= 1'b0;
            aborted_o         <= 1'b0;
            match_cnt_o       <= '0;
            first_match_vld_o <= 1'b0;
            first_match_idx_o <= '0;
        end else begin
            start_q <= start_i;
            armed   <= armed | ~start_i;

            if (state == ISSUE) begin
                timer <= '0;
            end else if (state == WAIT) begin
                timer <= timer + 1'b1;
            end

            if (accept) begin
                job_idx           <= '0;
                job_count         <= num_jobs_i;
                done_o            <= empty_batch;
                timeout_o         <= 1'b0;
                aborted_o         <= 1'b0;
                match_cnt_o       <= '0;
                first_match_vld_o <= 1'b0;
                first_match_idx_o <= '0;
            end

            if (job_done && eng_match_i) begin
                match_cnt_o <= match_cnt_o + One;
                if (!first_match_vld_o) begin
                    first_match_vld_o <= 1'b1;
                    first_match_idx_o <= job_idx;
                end
            end

            if (advance) begin
                job_idx <= job_idx + One;
            end

            if (finish) begin
                done_o <= 1'b1;
            end
            if (timed_out) begin
                done_o    <= 1'b1;
                timeout_o <= 1'b1;
            end
            if (abort_take) begin
                done_o    <= 1'b1;
                aborted_o <= 1'b1;
            end
        end
    end

    assign eng_start_o   = (state == ISSUE);
    assign eng_job_idx_o = job_idx;
    assign busy_o        = (state != IDLE);

endmodule

// File: tb/tb_match_job_sequencer.sv
// Directed bench for match_job_sequencer: a small engine model answers starts,
// and each scenario task checks its hand-computed results inline.
module tb_match_job_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [7:0] num_jobs;
    logic       eng_start;
    logic [7:0] eng_job_idx;
    logic       eng_done;
    logic       eng_match;
    logic       busy;
    logic       done;
    logic       timeout;
    logic       aborted;
    logic [7:0] match_cnt;
    logic       first_vld;
    logic [7:0] first_idx;

    logic         done_auto, match_auto;
    logic         done_man, match_man;
    logic         eng_auto;
    logic [7:0]   hang_idx;
    logic [255:0] match_mask;
    int           eng_cnt;
    logic [7:0]   eng_job;
    int           start_total;
    logic [7:0]   start_log [0:255];

    int errors;
    int checks;

    assign eng_done  = done_auto | done_man;
    assign eng_match = match_auto | match_man;

    match_job_sequencer #(
        .NumJobsWidth (8),
        .TimeoutCycles(16)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .start_i          (start),
        .abort_i          (abort),
        .num_jobs_i       (num_jobs),
        .eng_start_o      (eng_start),
        .eng_job_idx_o    (eng_job_idx),
        .eng_done_i       (eng_done),
        .eng_match_i      (eng_match),
        .busy_o           (busy),
        .done_o           (done),
        .timeout_o        (timeout),
        .aborted_o        (aborted),
        .match_cnt_o      (match_cnt),
        .first_match_vld_o(first_vld),
        .first_match_idx_o(first_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine model: logs every start and answers three cycles later unless the job is hung.
    always @(negedge clk) begin
        done_auto  = 1'b0;
        match_auto = 1'b0;
        if (eng_cnt > 0) begin
            eng_cnt = eng_cnt - 1;
            if (eng_cnt == 0) begin
                done_auto  = 1'b1;
                match_auto = match_mask[eng_job];
            end
        end
        if (eng_start === 1'b1) begin
            start_log[start_total[7:0]] = eng_job_idx;
            start_total = start_total + 1;
            if (eng_auto && eng_job_idx != hang_idx) begin
                eng_cnt = 3;
                eng_job = eng_job_idx;
            end
        end
    end

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (eng_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_eng_start: got %b expected 0", eng_start); end
        checks++; if ({timeout, aborted, first_vld} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {timeout, aborted, first_vld}); end
        checks++; if ({match_cnt, first_idx, eng_job_idx} !== 24'h0) begin errors++; $display("[TB] FAIL reset_fields: got %h expected 000000", {match_cnt, first_idx, eng_job_idx}); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_normal_batch;
        bit ok;
        int base;
        base       = start_total;
        eng_auto   = 1'b1;
        hang_idx   = 8'hFF;
        match_mask = '0;
        match_mask[1] = 1'b1;
        match_mask[3] = 1'b1;
        num_jobs = 8'd4;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (eng_start !== 1'b1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL normal_first_issue: got start=%b busy=%b expected 1 1", eng_start, busy); end
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL normal_done_wait: got no done expected done within 200 cycles"); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL normal_busy_at_done: got %b expected 0", busy); end
        checks++; if (start_total - base !== 4) begin errors++; $display("[TB] FAIL normal_start_count: got %0d expected 4", start_total - base); end
        for (int j = 0; j < 4; j++) begin
            checks++; if (start_log[8'(base + j)] !== 8'(j)) begin errors++; $display("[TB] FAIL normal_idx%0d: got %0d expected %0d", j, start_log[8'(base + j)], j); end
        end
        checks++; if (match_cnt !== 8'd2) begin errors++; $display("[TB] FAIL normal_match_cnt: got %0d expected 2", match_cnt); end
        checks++; if (first_vld !== 1'b1 || first_idx !== 8'd1) begin errors++; $display("[TB] FAIL normal_first_match: got vld=%b idx=%0d expected 1 1", first_vld, first_idx); end
        checks++; if (timeout !== 1'b0 || aborted !== 1'b0) begin errors++; $display("[TB] FAIL normal_flags: got to=%b ab=%b expected 0 0", timeout, aborted); end
    endtask

    task automatic test_empty_batch;
        int base;
        base     = start_total;
        num_jobs = 8'd0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL empty_done: got done=%b busy=%b expected 1 0", done, busy); end
        checks++; if (match_cnt !== 8'd0 || first_vld !== 1'b0) begin errors++; $display("[TB] FAIL empty_cleared: got cnt=%0d vld=%b expected 0 0", match_cnt, first_vld); end
        repeat (4) @(negedge clk);
        checks++; if (start_total - base !== 0) begin errors++; $display("[TB] FAIL empty_no_start: got %0d starts expected 0", start_total - base); end
    endtask

    task automatic test_timeout;
        bit found;
        int n;
        int base;
        base       = start_total;
        eng_auto   = 1'b1;
        hang_idx   = 8'd1;
        match_mask = '0;
        match_mask[0] = 1'b1;
        num_jobs = 8'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (eng_start === 1'b1 && eng_job_idx === 8'd1) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (!found) begin errors++; $display("[TB] FAIL timeout_job1_issue: got none expected job 1 start"); end
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n++;
            if (timeout === 1'b1) break;
        end
        checks++; if (n !== 17) begin errors++; $display("[TB] FAIL timeout_latency: got %0d cycles after issue expected 17", n); end
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL timeout_done: got done=%b busy=%b expected 1 0", done, busy); end
        checks++; if (match_cnt !== 8'd1 || first_idx !== 8'd0 || first_vld !== 1'b1) begin errors++; $display("[TB] FAIL timeout_held_status: got cnt=%0d idx=%0d vld=%b expected 1 0 1", match_cnt, first_idx, first_vld); end
        repeat (5) @(negedge clk);
        checks++; if (start_total - base !== 2) begin errors++; $display("[TB] FAIL timeout_start_count: got %0d expected 2", start_total - base); end
        hang_idx = 8'hFF;
    endtask

    task automatic test_abort_vs_done;
        int base;
        base     = start_total;
        eng_auto = 1'b0;
        num_jobs = 8'd5;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j < 3; j++) begin
            checks++; if (eng_start !== 1'b1 || eng_job_idx !== 8'(j)) begin errors++; $display("[TB] FAIL abort_issue%0d: got start=%b idx=%0d expected 1 %0d", j, eng_start, eng_job_idx, j); end
            @(negedge clk);
            done_man  = 1'b1;
            match_man = (j != 1);
            abort     = (j == 2);
            @(negedge clk);
            done_man  = 1'b0;
            match_man = 1'b0;
            abort     = 1'b0;
        end
        checks++; if (aborted !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_status: got ab=%b done=%b busy=%b expected 1 1 0", aborted, done, busy); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("[TB] FAIL abort_timeout_flag: got %b expected 0", timeout); end
        checks++; if (match_cnt !== 8'd1 || first_idx !== 8'd0) begin errors++; $display("[TB] FAIL abort_match_cnt: got cnt=%0d idx=%0d expected 1 0", match_cnt, first_idx); end
        repeat (10) @(negedge clk);
        checks++; if (start_total - base !== 3) begin errors++; $display("[TB] FAIL abort_no_more_starts: got %0d expected 3", start_total - base); end
    endtask

    task automatic test_start_while_busy;
        bit ok;
        int base;
        base       = start_total;
        eng_auto   = 1'b1;
        match_mask = '0;
        match_mask[0] = 1'b1;
        match_mask[2] = 1'b1;
        num_jobs = 8'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start    = 1'b1;
        num_jobs = 8'd9;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL busy_done_wait: got no done expected done within 200 cycles"); end
        checks++; if (start_total - base !== 3) begin errors++; $display("[TB] FAIL busy_start_count: got %0d expected 3", start_total - base); end
        checks++; if (match_cnt !== 8'd2 || first_idx !== 8'd0) begin errors++; $display("[TB] FAIL busy_match: got cnt=%0d idx=%0d expected 2 0", match_cnt, first_idx); end
        repeat (3) @(negedge clk);
        checks++; if (done !== 1'b1 || match_cnt !== 8'd2 || busy !== 1'b0) begin errors++; $display("[TB] FAIL busy_status_held: got done=%b cnt=%0d busy=%b expected 1 2 0", done, match_cnt, busy); end
    endtask

    task automatic test_reset_mid_wait;
        int base;
        eng_auto = 1'b1;
        hang_idx = 8'd0;
        num_jobs = 8'd4;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre_busy: got %b expected 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({busy, done, eng_start, timeout, aborted, first_vld} !== 6'b0) begin errors++; $display("[TB] FAIL rst_async_flags: got %b expected 000000", {busy, done, eng_start, timeout, aborted, first_vld}); end
        checks++; if ({match_cnt, first_idx, eng_job_idx} !== 24'h0) begin errors++; $display("[TB] FAIL rst_async_fields: got %h expected 000000", {match_cnt, first_idx, eng_job_idx}); end
        @(negedge clk);
        rst_n = 1'b1;
        base  = start_total;
        repeat (5) @(negedge clk);
        checks++; if (busy !== 1'b0 || start_total - base !== 0) begin errors++; $display("[TB] FAIL rst_held_start: got busy=%b starts=%0d expected 0 0", busy, start_total - base); end
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        checks++; if (eng_start !== 1'b1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL rst_new_rise: got start=%b busy=%b expected 1 1", eng_start, busy); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        checks++; if (aborted !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_cleanup_abort: got ab=%b busy=%b expected 1 0", aborted, busy); end
        hang_idx = 8'hFF;
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        start_total = 0;
        eng_cnt     = 0;
        eng_job     = 8'd0;
        eng_auto    = 1'b0;
        hang_idx    = 8'hFF;
        match_mask  = '0;
        done_man    = 1'b0;
        match_man   = 1'b0;
        rst_n       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        num_jobs    = 8'd0;
        test_reset();
        test_normal_batch();
        test_empty_batch();
        test_timeout();
        test_abort_vs_done();
        test_start_while_busy();
        test_reset_mid_wait();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
